// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates a pixel-fetch port and a CPU port onto one synchronous VRAM.
// Optional macro VRAM_CPU_SLOT_EN reserves slot 3 of the 4-slot cycle for the CPU.
module vram_arbiter #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_sync,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_ack,
  output logic              pix_rvalid,
  output logic [7:0]        pix_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  logic [1:0]        slot_r;
  logic              pix_grant_s;
  logic              cpu_grant_s;
  logic              xfer_s;
  logic              cpu_wr_s;
  logic              rd_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_we_r;
  logic [7:0]        mem_wdata_r;
  logic              tag1_v_r;
  logic              tag1_cpu_r;
  logic              tag2_v_r;
  logic              tag2_cpu_r;
  logic              pix_rvalid_r;
  logic              cpu_rvalid_r;
  logic [7:0]        pix_rdata_r;
  logic [7:0]        cpu_rdata_r;

  // Free-running slot counter, realigned to 0 by line_sync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_r <= 2'd0;
    end else if (line_sync) begin
      slot_r <= 2'd0;
    end else begin
      slot_r <= slot_r + 2'd1;
    end
  end

  // Grant logic: pixel first, except the CPU-reserved slot when enabled.
  always_comb begin
    pix_grant_s = 1'b0;
    cpu_grant_s = 1'b0;
    if (!rst) begin
      pix_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end
`ifdef VRAM_CPU_SLOT_EN
    else if (slot_r == 2'd3) begin
      cpu_grant_s = cpu_req;
      pix_grant_s = pix_req & ~cpu_req;
    end
`endif
    else begin
      pix_grant_s = pix_req;
      cpu_grant_s = cpu_req & ~pix_req;
    end
  end

  assign xfer_s   = pix_grant_s | cpu_grant_s;
  assign cpu_wr_s = cpu_grant_s & cpu_we;
  assign rd_s     = xfer_s & ~cpu_wr_s;

  // VRAM command register; the address holds between transfers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 8'h00;
    end else begin
      mem_we_r <= cpu_wr_s;
      if (pix_grant_s) begin
        mem_addr_r <= pix_addr;
      end else if (cpu_grant_s) begin
        mem_addr_r <= cpu_addr;
      end
      if (cpu_wr_s) begin
        mem_wdata_r <= cpu_wdata;
      end
    end
  end

  // Read tag pipeline tracks owner until VRAM data is available.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag1_v_r   <= 1'b0;
      tag1_cpu_r <= 1'b0;
      tag2_v_r   <= 1'b0;
      tag2_cpu_r <= 1'b0;
    end else begin
      tag1_v_r   <= rd_s;
      tag1_cpu_r <= cpu_grant_s;
      tag2_v_r   <= tag1_v_r;
      tag2_cpu_r <= tag1_cpu_r;
    end
  end

  // Return stage: capture read data for its owner; data holds until the next return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_rvalid_r <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      pix_rdata_r  <= 8'h00;
      cpu_rdata_r  <= 8'h00;
    end else begin
      pix_rvalid_r <= tag2_v_r & ~tag2_cpu_r;
      cpu_rvalid_r <= tag2_v_r & tag2_cpu_r;
      if (tag2_v_r && !tag2_cpu_r) begin
        pix_rdata_r <= mem_rdata;
      end
      if (tag2_v_r && tag2_cpu_r) begin
        cpu_rdata_r <= mem_rdata;
      end
    end
  end

  assign pix_ack    = pix_grant_s;
  assign cpu_ack    = cpu_grant_s;
  assign mem_addr   = mem_addr_r;
  assign mem_we     = mem_we_r;
  assign mem_wdata  = mem_wdata_r;
  assign pix_rvalid = pix_rvalid_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign pix_rdata  = pix_rdata_r;
  assign cpu_rdata  = cpu_rdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios for vram_arbiter with a read-return scoreboard.
// Expected grants honour VRAM_CPU_SLOT_EN when the bench is built with it.
module tb_vram_arbiter;

`ifdef VRAM_CPU_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        line_sync;
  logic        pix_req;
  logic [14:0] pix_addr;
  logic        pix_ack;
  logic        pix_rvalid;
  logic [7:0]  pix_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  typedef struct {
    bit         own;
    logic [7:0] data;
    int         cyc;
  } rd_t;

  rd_t        sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] mem [0:32767];

  vram_arbiter dut (
    .clk(clk), .rst(rst), .line_sync(line_sync),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_ack(pix_ack),
    .pix_rvalid(pix_rvalid), .pix_rdata(pix_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous VRAM model, 1-cycle read latency.
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
    mem[15'h1800] <= 8'hA5;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic set_req(input bit pr, input logic [14:0] pa, input bit cr, input bit we,
                         input logic [14:0] ca, input logic [7:0] wd);
    pix_req = pr; pix_addr = pa; cpu_req = cr; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
  endtask

  task automatic expect_rd(input bit own, input logic [7:0] data);
    rd_t e;
    e.own = own; e.data = data; e.cyc = cyc + 3;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every read return and checks grant exclusivity.
  always @(negedge clk) begin
    chk("ack_excl", {31'd0, pix_ack & cpu_ack}, 32'd0);
    if (pix_rvalid || cpu_rvalid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rv_unexpected: pix_rvalid=%0b cpu_rvalid=%0b expected none (cycle %0d)",
                 pix_rvalid, cpu_rvalid, cyc);
      end else begin
        rd_t e;
        e = sb.pop_front();
        chk("rv_excl", {31'd0, pix_rvalid & cpu_rvalid}, 32'd0);
        chk("rv_owner", {31'd0, cpu_rvalid}, {31'd0, e.own});
        chk("rv_cycle", cyc, e.cyc);
        chk("rv_data", {24'd0, (cpu_rvalid ? cpu_rdata : pix_rdata)}, {24'd0, e.data});
      end
    end
  end

  initial begin
    int sseq [8] = '{0, 1, 2, 0, 1, 2, 3, 0};
    bit exp_cpu;

    // Reset with both requesters active.
    rst = 1'b0; line_sync = 1'b0;
    set_req(1'b1, 15'h1800, 1'b1, 1'b0, 15'h0123, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("rst_pix_ack", {31'd0, pix_ack}, 32'd0);
      chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
      chk("rst_rvalid", {30'd0, pix_rvalid, cpu_rvalid}, 32'd0);
    end
    step(); rst = 1'b1;
    set_req(1'b1, 15'h0000, 1'b1, 1'b0, 15'h0123, 8'h00);
    expect_rd(1'b0, 8'h00);
    @(negedge clk);
    chk("first_pix_ack", {31'd0, pix_ack}, 32'd1);
    chk("first_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    step(); set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    idle(4);

    // Single pixel read.
    step(); set_req(1'b1, 15'h1800, 1'b0, 1'b0, 15'h0000, 8'h00);
    expect_rd(1'b0, 8'hA5);
    @(negedge clk);
    chk("pix_ack", {31'd0, pix_ack}, 32'd1);
    chk("pix_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    step(); set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    @(negedge clk);
    chk("pix_mem_addr", {17'd0, mem_addr}, 32'h1800);
    chk("pix_mem_we", {31'd0, mem_we}, 32'd0);
    chk("idle_pix_ack", {31'd0, pix_ack}, 32'd0);
    step(); @(negedge clk);
    chk("hold_mem_addr", {17'd0, mem_addr}, 32'h1800);
    idle(3);
    chk("hold_pix_rdata", {24'd0, pix_rdata}, 32'hA5);

    // CPU write then read back.
    step(); set_req(1'b0, 15'h0000, 1'b1, 1'b1, 15'h0123, 8'h5A);
    @(negedge clk);
    chk("wr_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    step(); set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    @(negedge clk);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
    chk("wr_mem_addr", {17'd0, mem_addr}, 32'h0123);
    step(); set_req(1'b0, 15'h0000, 1'b1, 1'b0, 15'h0123, 8'h00);
    expect_rd(1'b1, 8'h5A);
    @(negedge clk);
    chk("rd_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    step(); set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    @(negedge clk);
    chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
    idle(4);

    // Back-to-back transfers from alternating owners, returned in issue order.
    step(); set_req(1'b1, 15'h1800, 1'b0, 1'b0, 15'h0000, 8'h00); expect_rd(1'b0, 8'hA5);
    @(negedge clk); chk("b2b_pix0", {31'd0, pix_ack}, 32'd1);
    step(); set_req(1'b0, 15'h0000, 1'b1, 1'b0, 15'h0123, 8'h00); expect_rd(1'b1, 8'h5A);
    @(negedge clk); chk("b2b_cpu1", {31'd0, cpu_ack}, 32'd1);
    step(); set_req(1'b1, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00); expect_rd(1'b0, 8'h00);
    @(negedge clk); chk("b2b_pix2", {31'd0, pix_ack}, 32'd1);
    step(); set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    idle(4);

    // Contention for 8 cycles starting from slot 0.
    step(); line_sync = 1'b1;
    step(); line_sync = 1'b0;
    set_req(1'b1, 15'h1800, 1'b1, 1'b0, 15'h0123, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      exp_cpu = SLOT_EN && ((i % 4) == 3);
      if (exp_cpu) expect_rd(1'b1, 8'h5A);
      else expect_rd(1'b0, 8'hA5);
      @(negedge clk);
      chk("cont_pix_ack", {31'd0, pix_ack}, {31'd0, !exp_cpu});
      chk("cont_cpu_ack", {31'd0, cpu_ack}, {31'd0, exp_cpu});
    end
    step(); set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    idle(4);

    // line_sync in slot 2 under contention pushes the CPU slot out.
    step(); line_sync = 1'b1;
    step(); line_sync = 1'b0;
    set_req(1'b1, 15'h1800, 1'b1, 1'b0, 15'h0123, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      line_sync = (i == 2);
      exp_cpu = SLOT_EN && (sseq[i] == 3);
      if (exp_cpu) expect_rd(1'b1, 8'h5A);
      else expect_rd(1'b0, 8'hA5);
      @(negedge clk);
      chk("ls_pix_ack", {31'd0, pix_ack}, {31'd0, !exp_cpu});
      chk("ls_cpu_ack", {31'd0, cpu_ack}, {31'd0, exp_cpu});
    end
    step(); line_sync = 1'b0;
    set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    idle(6);

    // Reset with two reads in flight.
    step(); set_req(1'b1, 15'h1800, 1'b0, 1'b0, 15'h0000, 8'h00);
    @(negedge clk); chk("mf_ack0", {31'd0, pix_ack}, 32'd1);
    step(); set_req(1'b1, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    @(negedge clk); chk("mf_ack1", {31'd0, pix_ack}, 32'd1);
    step(); rst = 1'b0;
    set_req(1'b1, 15'h1800, 1'b1, 1'b0, 15'h0123, 8'h00);
    @(negedge clk);
    chk("mf_rst_pix_ack", {31'd0, pix_ack}, 32'd0);
    chk("mf_rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    step(); rst = 1'b1;
    set_req(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00);
    @(negedge clk);
    chk("mf_mem_addr", {17'd0, mem_addr}, 32'd0);
    chk("mf_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mf_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("mf_pix_rdata", {24'd0, pix_rdata}, 32'd0);
    chk("mf_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("mf_rvalid", {30'd0, pix_rvalid, cpu_rvalid}, 32'd0);
    idle(6);

    chk("sb_leftover", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
